// File: rtl/qdr_init_seq.sv
// qdr_init_seq: power-up and recovery sequencer for the QDRII MIG example design.
// Qualifies the clock-generator lock, holds the MIG in reset until the clocks are
// stable, waits for calibration with a timeout and a bounded retry count, then
// enables the traffic generator and counts its compare errors.
//
// Ports:
//   sys_clk        sole clock, rising edge
//   sys_rst_n      asynchronous active-low reset
//   locked         raw MMCM lock (asynchronous, synchronized internally)
//   cal_done       MIG calibration complete (asynchronous, synchronized internally)
//   compare_error  traffic-generator mismatch flag, one per cycle
//   err_clr        synchronous pulse clearing err_cnt and err_sticky
//   mig_rst        active-high reset to the MIG
//   tg_enable      traffic-generator enable (RUN only)
//   init_done      high only in RUN
//   init_fail      high only in FAIL
//   retry_cnt      calibration retries consumed
//   err_cnt        saturating compare-error count
//   err_sticky     set by any counted error
//   state          IDLE=0 LOCK_WAIT=1 MIG_RST=2 CAL_WAIT=3 RUN=4 FAIL=5
module qdr_init_seq #(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int MIG_RST_CYCLES     = 64,
   parameter int CAL_TIMEOUT        = 1048576,
   parameter int MAX_RETRY          = 3,
   parameter int ERR_CNT_W          = 16
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 locked,
   input  logic                 cal_done,
   input  logic                 compare_error,
   input  logic                 err_clr,
   output logic                 mig_rst,
   output logic                 tg_enable,
   output logic                 init_done,
   output logic                 init_fail,
   output logic [1:0]           retry_cnt,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic                 err_sticky,
   output logic [2:0]           state
);

   localparam int MAX_AB = (LOCK_STABLE_CYCLES > MIG_RST_CYCLES) ? LOCK_STABLE_CYCLES : MIG_RST_CYCLES;
   localparam int MAX_P  = (MAX_AB > CAL_TIMEOUT) ? MAX_AB : CAL_TIMEOUT;
   localparam int TW     = $clog2(MAX_P);

   localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [TW-1:0] RST_LAST  = TW'(MIG_RST_CYCLES - 1);
   localparam logic [TW-1:0] CAL_LAST  = TW'(CAL_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOCK_WAIT = 3'd1,
      S_MIG_RST   = 3'd2,
      S_CAL_WAIT  = 3'd3,
      S_RUN       = 3'd4,
      S_FAIL      = 3'd5
   } state_t;

   state_t        st;
   logic [TW-1:0] timer;
   logic          lk_ff1, lk_s;
   logic          cd_ff1, cd_s;
   logic          cal_lost;
   logic          retry_ok;
   logic          counted;

   assign state = st;

   // 2-FF synchronizers; every decision below uses only lk_s / cd_s.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         lk_ff1 <= 1'b0;
         lk_s   <= 1'b0;
         cd_ff1 <= 1'b0;
         cd_s   <= 1'b0;
      end else begin
         lk_ff1 <= locked;
         lk_s   <= lk_ff1;
         cd_ff1 <= cal_done;
         cd_s   <= cd_ff1;
      end
   end

   // Calibration timeout and calibration loss in RUN share one retry/FAIL rule.
   // cal_done arriving on the expiry cycle wins, hence the !cd_s term.
   assign cal_lost = ((st == S_CAL_WAIT) && !cd_s && (timer == CAL_LAST)) ||
                     ((st == S_RUN) && !cd_s);
   assign retry_ok = int'(retry_cnt) < MAX_RETRY;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         st        <= S_IDLE;
         timer     <= '0;
         retry_cnt <= '0;
         mig_rst   <= 1'b1;
         tg_enable <= 1'b0;
         init_done <= 1'b0;
         init_fail <= 1'b0;
      end else if ((st != S_IDLE) && !lk_s) begin
         // Lock loss overrides everything else.
         st        <= S_IDLE;
         timer     <= '0;
         retry_cnt <= '0;
         mig_rst   <= 1'b1;
         tg_enable <= 1'b0;
         init_done <= 1'b0;
         init_fail <= 1'b0;
      end else if (cal_lost) begin
         timer     <= '0;
         mig_rst   <= 1'b1;
         tg_enable <= 1'b0;
         init_done <= 1'b0;
         if (retry_ok) begin
            retry_cnt <= retry_cnt + 2'd1;
            st        <= S_MIG_RST;
         end else begin
            st        <= S_FAIL;
            init_fail <= 1'b1;
         end
      end else begin
         case (st)
            S_IDLE: begin
               if (lk_s) begin
                  st    <= S_LOCK_WAIT;
                  timer <= '0;
               end
            end
            S_LOCK_WAIT: begin
               if (timer == LOCK_LAST) begin
                  st    <= S_MIG_RST;
                  timer <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_MIG_RST: begin
               if (timer == RST_LAST) begin
                  st      <= S_CAL_WAIT;
                  timer   <= '0;
                  mig_rst <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_CAL_WAIT: begin
               if (cd_s) begin
                  st        <= S_RUN;
                  timer     <= '0;
                  tg_enable <= 1'b1;
                  init_done <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_RUN:   ;
            S_FAIL:  ;
            default: begin
               st        <= S_IDLE;
               timer     <= '0;
               mig_rst   <= 1'b1;
               tg_enable <= 1'b0;
               init_done <= 1'b0;
               init_fail <= 1'b0;
            end
         endcase
      end
   end

   // Error counting is gated by the registered state, so only RUN counts.
   assign counted = compare_error && (st == S_RUN);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         err_cnt    <= '0;
         err_sticky <= 1'b0;
      end else if (counted) begin
         err_sticky <= 1'b1;
         if (err_clr) begin
            err_cnt <= ERR_CNT_W'(1);
         end else if (err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
         end
      end else if (err_clr) begin
         err_cnt    <= '0;
         err_sticky <= 1'b0;
      end
   end

endmodule
